// File: rtl/conv_mac_accumulator.sv
// Window accumulator behind the Vedic multiplier: sums TAPS products per
// convolution window and hands the sum off through a registered valid/ready port.
module conv_mac_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int TAPS   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic [7:0]        tap_count
);

    localparam logic [7:0] LAST = 8'(TAPS - 1);

    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_flag;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_sum;
    logic             r_out_ovf;

    logic             w_last;
    logic             w_hold;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_fire;
    logic [ACC_W:0]   w_sum;

    assign w_last     = (r_cnt == LAST);
    assign w_hold     = r_out_valid && !out_ready;
    assign w_in_ready = !w_hold || !w_last;
    // a product presented during clear is dropped, never accumulated
    assign w_accept   = in_valid && w_in_ready && !clear;
    assign w_fire     = w_accept && w_last;
    assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(product);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (clear || w_fire) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (w_accept) begin
            r_acc  <= w_sum[ACC_W-1:0];
            r_cnt  <= r_cnt + 8'd1;
            r_flag <= r_flag | w_sum[ACC_W];
        end
    end

    // load on final tap wins over drain so back-to-back results have no bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum[ACC_W-1:0];
            r_out_ovf   <= r_flag | w_sum[ACC_W];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_sum      = r_out_sum;
    assign out_overflow = r_out_ovf;
    assign tap_count    = r_cnt;

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Scoreboard bench for conv_mac_accumulator: directed windows, expected sums
// queued at stimulus time and checked by an independent output monitor.
module tb_conv_mac_accumulator;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        use2;
    logic        w_in_valid2;
    logic [31:0] product;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [39:0] out_sum;
    logic        out_overflow;
    logic [7:0]  tap_count;

    logic        in_ready2;
    logic        out_valid2;
    logic [33:0] out_sum2;
    logic        out_overflow2;
    logic [7:0]  tap_count2;

    int checks;
    int passes;
    int stall_drops;

    logic [40:0] q1[$];
    logic [34:0] q2[$];

    assign w_in_valid2 = in_valid & use2;

    conv_mac_accumulator #(.PROD_W(32), .ACC_W(40), .TAPS(9)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .product(product),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_overflow(out_overflow), .tap_count(tap_count)
    );

    conv_mac_accumulator #(.PROD_W(32), .ACC_W(34), .TAPS(9)) dut34 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(w_in_valid2), .in_ready(in_ready2), .product(product),
        .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
        .out_overflow(out_overflow2), .tap_count(tap_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // monitor: a handshake seen at the falling edge completes on the next rise
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q1.size() == 0) chk("unexpected_result40", {24'd0, out_sum}, 64'd0);
            else begin
                logic [40:0] e;
                e = q1.pop_front();
                chk("sum40", {24'd0, out_sum}, {24'd0, e[39:0]});
                chk("ovf40", {63'd0, out_overflow}, {63'd0, e[40]});
            end
        end
        if (!rst && out_valid2 && out_ready) begin
            if (q2.size() == 0) chk("unexpected_result34", {30'd0, out_sum2}, 64'd0);
            else begin
                logic [34:0] e;
                e = q2.pop_front();
                chk("sum34", {30'd0, out_sum2}, {30'd0, e[33:0]});
                chk("ovf34", {63'd0, out_overflow2}, {63'd0, e[34]});
            end
        end
    end

    // present one product and hold it until accepted (bounded)
    task automatic send(input logic [31:0] p);
        int n;
        in_valid = 1'b1;
        product  = p;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("send_timeout", 64'd1, 64'd0);
        if (n > 0) stall_drops++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        product  = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        checks = 0;
        passes = 0;
        stall_drops = 0;
        rst = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        use2 = 1'b0;
        product = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum", {24'd0, out_sum}, 64'd0);
        chk("rst_tap_count", {56'd0, tap_count}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        idle(1);

        // window 1..9
        q1.push_back({1'b0, 40'd45});
        for (int i = 1; i <= 9; i++) send(32'(i));
        chk("w1_valid_next", {63'd0, out_valid}, 64'd1);
        chk("w1_tap_zero", {56'd0, tap_count}, 64'd0);
        idle(1);
        chk("w1_valid_drop", {63'd0, out_valid}, 64'd0);

        // all-ones products on both widths
        use2 = 1'b1;
        q1.push_back({1'b0, 40'h8_FFFF_FFF7});
        q2.push_back({1'b1, 34'h0_FFFF_FFF7});
        for (int i = 0; i < 9; i++) send(32'hFFFF_FFFF);
        idle(2);
        use2 = 1'b0;

        // stall: 18 held, 27 waits at the final tap
        out_ready = 1'b0;
        q1.push_back({1'b0, 40'd18});
        for (int i = 0; i < 9; i++) send(32'd2);
        q1.push_back({1'b0, 40'd27});
        for (int i = 0; i < 8; i++) send(32'd3);
        in_valid = 1'b1;
        product  = 32'd3;
        #1;
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_tap", {56'd0, tap_count}, 64'd8);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_sum", {24'd0, out_sum}, 64'd18);
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_sum", {24'd0, out_sum}, 64'd27);
        idle(2);

        // back-to-back windows with continuous input
        stall_drops = 0;
        q1.push_back({1'b0, 40'd9});
        q1.push_back({1'b0, 40'd90});
        q1.push_back({1'b0, 40'd900});
        for (int i = 0; i < 9; i++) send(32'd1);
        for (int i = 0; i < 9; i++) send(32'd10);
        for (int i = 0; i < 9; i++) send(32'd100);
        chk("stream_no_stall", 64'(stall_drops), 64'd0);
        idle(2);

        // clear with a pending earlier result
        out_ready = 1'b0;
        q1.push_back({1'b0, 40'd45});
        for (int i = 0; i < 9; i++) send(32'd5);
        for (int i = 0; i < 4; i++) send(32'd100);
        clear = 1'b1;
        in_valid = 1'b1;
        product = 32'd100;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_tap", {56'd0, tap_count}, 64'd0);
        chk("clear_keeps_sum", {24'd0, out_sum}, 64'd45);
        chk("clear_keeps_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        q1.push_back({1'b0, 40'd9});
        for (int i = 0; i < 9; i++) send(32'd1);
        idle(2);

        // async reset mid-window with a pending (never delivered) result
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(32'd4);
        for (int i = 0; i < 5; i++) send(32'd4);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_sum", {24'd0, out_sum}, 64'd0);
        chk("arst_ovf", {63'd0, out_overflow}, 64'd0);
        chk("arst_tap", {56'd0, tap_count}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        q1.push_back({1'b0, 40'd63});
        for (int i = 0; i < 9; i++) send(32'd7);
        idle(1);

        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("q40_drained", 64'(q1.size()), 64'd0);
        chk("q34_drained", 64'(q2.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
